// File: rtl/mm_pkg.sv
// mm_pkg: shared widths, FSM state type and the lane round/relu/saturate
// helper used by the residual-add stage and later requant stages.
// Contents: A_SIZE_DEF / DATA_WIDTH_DEF / SHIFT_WIDTH_DEF defaults, SUM_WIDTH
// (lane sum width), state_t {IDLE, RUN, DRAIN}, round_sat(sum, shift, relu).
package mm_pkg;
    localparam int A_SIZE_DEF      = 16;
    localparam int DATA_WIDTH_DEF  = 8;
    localparam int SHIFT_WIDTH_DEF = 3;
    localparam int SUM_WIDTH       = DATA_WIDTH_DEF + 3;

    localparam logic signed [SUM_WIDTH:0] SAT_MAX = (SUM_WIDTH + 1)'(2 ** (DATA_WIDTH_DEF - 1) - 1);
    localparam logic signed [SUM_WIDTH:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    // One extra bit of headroom keeps sum + rounding constant from overflowing.
    // rnd is 2^(shift-1), or 0 when shift is 0, so one expression covers both cases.
    function automatic logic signed [DATA_WIDTH_DEF-1:0] round_sat(
        input logic signed [SUM_WIDTH-1:0]       sum,
        input logic        [SHIFT_WIDTH_DEF-1:0] shift,
        input logic                              relu
    );
        logic signed [SUM_WIDTH:0] ext;
        logic signed [SUM_WIDTH:0] rnd;
        logic signed [SUM_WIDTH:0] r;
        ext = (SUM_WIDTH + 1)'(sum);
        rnd = (SUM_WIDTH + 1)'(1) << shift;
        rnd = rnd >>> 1;
        r   = (ext + rnd) >>> shift;
        if (relu && r < 0) r = '0;
        if (r > SAT_MAX) r = SAT_MAX;
        else if (r < SAT_MIN) r = SAT_MIN;
        return r[DATA_WIDTH_DEF-1:0];
    endfunction
endpackage

// File: rtl/mm_lane_requant.sv
// mm_lane_requant: one lane of the second pipeline stage; rounds, optionally
// clamps negatives, and saturates a lane sum to int8.
// Ports: sum (signed lane sum), shift (right shift 0..7), relu (clamp enable),
// res (saturated int8 result).
module mm_lane_requant
    import mm_pkg::*;
(
    input  logic signed [SUM_WIDTH-1:0]       sum,
    input  logic        [SHIFT_WIDTH_DEF-1:0] shift,
    input  logic                              relu,
    output logic signed [DATA_WIDTH_DEF-1:0]  res
);
    always_comb res = round_sat(sum, shift, relu);
endmodule

// File: rtl/mm_residual_add.sv
// mm_residual_add: joins the mm_ultra int8 output stream with a residual
// stream beat-for-beat, adds per lane, rounds/shifts, optional ReLU, saturates,
// and frames each job by a configured beat count.
// Ports: clk, rst_n (sync active-low); start + cfg_* (job setup, IDLE only);
// in_a_* (matmul stream), in_b_* (residual stream), out_* (result stream);
// busy (not IDLE), done (one-cycle completion pulse), err_last (sticky
// last-flag misalignment, cleared on the next accepted start).
module mm_residual_add
    import mm_pkg::*;
#(
    parameter int A_SIZE      = A_SIZE_DEF,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int SHIFT_WIDTH = SHIFT_WIDTH_DEF,
    parameter int ROWS_WIDTH  = 10,
    parameter int BLK_WIDTH   = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [ROWS_WIDTH-1:0]        cfg_rows,
    input  logic [BLK_WIDTH-1:0]         cfg_blocks,
    input  logic [SHIFT_WIDTH-1:0]       cfg_shift,
    input  logic                         cfg_relu,
    input  logic                         in_a_valid,
    output logic                         in_a_ready,
    input  logic                         in_a_last,
    input  logic [A_SIZE*DATA_WIDTH-1:0] in_a_data,
    input  logic                         in_b_valid,
    output logic                         in_b_ready,
    input  logic                         in_b_last,
    input  logic [A_SIZE*DATA_WIDTH-1:0] in_b_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic [A_SIZE*DATA_WIDTH-1:0] out_data,
    output logic                         busy,
    output logic                         done,
    output logic                         err_last
);
    localparam int TW = ROWS_WIDTH + BLK_WIDTH;

    state_t                         state;
    logic [SHIFT_WIDTH-1:0]         shift_q;
    logic                           relu_q;
    logic [TW-1:0]                  total_q;
    logic [TW-1:0]                  cnt_q;
    logic [TW-1:0]                  total_d;
    logic                           s1_valid;
    logic                           s1_last;
    logic signed [SUM_WIDTH-1:0]    s1_sum [A_SIZE];
    logic [A_SIZE*DATA_WIDTH-1:0]   req;
    logic                           s2_can;
    logic                           s1_can_accept;
    logic                           fire;
    logic                           is_last;

    always_comb begin
        total_d       = TW'(cfg_rows) * TW'(cfg_blocks);
        s2_can        = !out_valid || out_ready;
        s1_can_accept = !s1_valid || s2_can;
        fire          = (state == RUN) && in_a_valid && in_b_valid && s1_can_accept;
        is_last       = cnt_q == total_q - 1'b1;
        in_a_ready    = fire;
        in_b_ready    = fire;
        busy          = state != IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            shift_q  <= '0;
            relu_q   <= 1'b0;
            total_q  <= '0;
            cnt_q    <= '0;
            done     <= 1'b0;
            err_last <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    shift_q  <= cfg_shift;
                    relu_q   <= cfg_relu;
                    total_q  <= total_d;
                    cnt_q    <= '0;
                    err_last <= 1'b0;
                    if (total_d == '0) done <= 1'b1;
                    else state <= RUN;
                end
                RUN: if (fire) begin
                    cnt_q <= cnt_q + 1'b1;
                    if (in_a_last != is_last || in_b_last != is_last) err_last <= 1'b1;
                    if (is_last) state <= DRAIN;
                end
                DRAIN: if (out_valid && out_ready && out_last) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pipeline valids/tags; a stage loads only when its successor frees up.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            if (s1_can_accept) begin
                s1_valid <= fire;
                s1_last  <= fire && is_last;
            end
            if (s2_can) begin
                out_valid <= s1_valid;
                out_last  <= s1_valid && s1_last;
                if (s1_valid) out_data <= req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fire) begin
            for (int i = 0; i < A_SIZE; i++) begin
                s1_sum[i] <= SUM_WIDTH'($signed(in_a_data[i*DATA_WIDTH +: DATA_WIDTH]))
                           + SUM_WIDTH'($signed(in_b_data[i*DATA_WIDTH +: DATA_WIDTH]));
            end
        end
    end

    for (genvar i = 0; i < A_SIZE; i++) begin : g_lane
        mm_lane_requant u_lane (
            .sum  (s1_sum[i]),
            .shift(shift_q),
            .relu (relu_q),
            .res  (req[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end
endmodule
